// File: rtl/ahb_slave_if.sv
// AHB slave front end of the AHB-to-APB bridge.
// Qualifies AHB transfers into Valid for the bridge FSM, keeps a two-deep
// address/write-data history, decodes the APB slave select, returns APB read
// data and produces the two-cycle ERROR response for unmapped addresses.
module ahb_slave_if #(
    parameter logic [31:0] SLV0_BASE   = 32'h8000_0000,
    parameter logic [31:0] SLV1_BASE   = 32'h8400_0000,
    parameter logic [31:0] SLV2_BASE   = 32'h8800_0000,
    parameter logic [31:0] REGION_SIZE = 32'h0400_0000
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    output logic        Valid,
    output logic [31:0] Haddr1,
    output logic [31:0] Haddr2,
    output logic [31:0] Hdata1,
    output logic [31:0] Hdata2,
    output logic        Hwrite_reg,
    output logic [2:0]  Tempselx,
    output logic [31:0] Hrdata,
    output logic [1:0]  Hresp,
    output logic        Herr_stall
);

    typedef enum logic [1:0] {
        ST_OKAY = 2'b00,
        ST_ERR1 = 2'b01,
        ST_ERR2 = 2'b10
    } err_state_t;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    // Bounds are widened to 33 bits so a region ending at 4 GiB cannot wrap.
    localparam logic [32:0] MAP_LO = {1'b0, SLV0_BASE};
    localparam logic [32:0] MAP_HI = {1'b0, SLV2_BASE} + {1'b0, REGION_SIZE};

    err_state_t state;
    logic       active;
    logic       mapped;

    // Inclusive base, exclusive base + REGION_SIZE.
    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, REGION_SIZE};
        return (a >= lo) && (a < hi);
    endfunction

    // NONSEQ or SEQ while the bus is ready; IDLE and BUSY never qualify.
    assign active = Hreadyin && ((Htrans == 2'b10) || (Htrans == 2'b11));

    // Address-phase decode of the whole bridge window.
    always_comb begin
        mapped = ({1'b0, Haddr} >= MAP_LO) && ({1'b0, Haddr} < MAP_HI);
    end

    // Error cycles mask new transfers from the bridge FSM.
    assign Valid = active && mapped && (state == ST_OKAY);

    // APB read data goes straight back to the AHB master.
    assign Hrdata = Prdata;

    // Address/data/direction history, advancing only when the bus is ready.
    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) begin
            Haddr1     <= '0;
            Haddr2     <= '0;
            Hdata1     <= '0;
            Hdata2     <= '0;
            Hwrite_reg <= 1'b0;
        end else if (Hreadyin) begin
            Haddr1     <= Haddr;
            Haddr2     <= Haddr1;
            Hdata1     <= Hwdata;
            Hdata2     <= Hdata1;
            Hwrite_reg <= Hwrite;
        end
    end

    // One-hot APB slave select from the registered address.
    always_comb begin
        Tempselx = 3'b000;
        if (in_region(Haddr1, SLV0_BASE)) begin
            Tempselx = 3'b001;
        end else if (in_region(Haddr1, SLV1_BASE)) begin
            Tempselx = 3'b010;
        end else if (in_region(Haddr1, SLV2_BASE)) begin
            Tempselx = 3'b100;
        end
    end

    // Two-cycle ERROR response; outputs are registered alongside the state.
    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) begin
            state      <= ST_OKAY;
            Hresp      <= RESP_OKAY;
            Herr_stall <= 1'b0;
        end else begin
            case (state)
                ST_OKAY: begin
                    if (active && !mapped) begin
                        state      <= ST_ERR1;
                        Hresp      <= RESP_ERROR;
                        Herr_stall <= 1'b1;
                    end else begin
                        Hresp      <= RESP_OKAY;
                        Herr_stall <= 1'b0;
                    end
                end
                ST_ERR1: begin
                    state      <= ST_ERR2;
                    Hresp      <= RESP_ERROR;
                    Herr_stall <= 1'b0;
                end
                ST_ERR2: begin
                    state      <= ST_OKAY;
                    Hresp      <= RESP_OKAY;
                    Herr_stall <= 1'b0;
                end
                default: begin
                    state      <= ST_OKAY;
                    Hresp      <= RESP_OKAY;
                    Herr_stall <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Bench for ahb_slave_if: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural reference model.
module tb_ahb_slave_if;

    logic        Hclk = 1'b0;
    logic        Hreset = 1'b0;
    logic        Hwrite = 1'b0;
    logic        Hreadyin = 1'b0;
    logic [1:0]  Htrans = 2'b00;
    logic [31:0] Haddr = '0;
    logic [31:0] Hwdata = '0;
    logic [31:0] Prdata = '0;
    logic        Valid;
    logic [31:0] Haddr1, Haddr2, Hdata1, Hdata2;
    logic        Hwrite_reg;
    logic [2:0]  Tempselx;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;
    logic        Herr_stall;

    ahb_slave_if dut (
        .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin),
        .Htrans(Htrans), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata),
        .Valid(Valid), .Haddr1(Haddr1), .Haddr2(Haddr2), .Hdata1(Hdata1),
        .Hdata2(Hdata2), .Hwrite_reg(Hwrite_reg), .Tempselx(Tempselx),
        .Hrdata(Hrdata), .Hresp(Hresp), .Herr_stall(Herr_stall)
    );

    always #5 Hclk = ~Hclk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_a1 = '0, m_a2 = '0, m_d1 = '0, m_d2 = '0;
    logic        m_w = 1'b0;
    int          m_err = 0;   // error cycles still to show: 2 = first, 1 = second

    function automatic bit in_map(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a <= 32'h8BFF_FFFF);
    endfunction

    function automatic logic [2:0] sel_of(input logic [31:0] a);
        longint idx;
        if (a < 32'h8000_0000) return 3'b000;
        idx = longint'(a - 32'h8000_0000) / longint'(32'h0400_0000);
        if (idx > 2) return 3'b000;
        return 3'(1 << idx);
    endfunction

    always @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) begin
            m_a1 <= '0; m_a2 <= '0; m_d1 <= '0; m_d2 <= '0; m_w <= 1'b0;
            m_err <= 0;
        end else begin
            if (Hreadyin) begin
                m_a1 <= Haddr; m_a2 <= m_a1;
                m_d1 <= Hwdata; m_d2 <= m_d1;
                m_w  <= Hwrite;
            end
            if (m_err > 0) m_err <= m_err - 1;
            else if (Hreadyin && Htrans[1] && !in_map(Haddr)) m_err <= 2;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] tr, input logic rdy, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] pr);
        Htrans = tr; Hreadyin = rdy; Hwrite = wr; Haddr = addr; Hwdata = wd; Prdata = pr;
    endtask

    task automatic chk_model();
        logic exp_valid;
        exp_valid = Hreadyin && Htrans[1] && in_map(Haddr) && (m_err == 0);
        chk("Valid", 32'(Valid), 32'(exp_valid));
        chk("Tempselx", 32'(Tempselx), 32'(sel_of(m_a1)));
        chk("Hrdata", Hrdata, Prdata);
        chk("Hresp", 32'(Hresp), (m_err != 0) ? 32'd1 : 32'd0);
        chk("Herr_stall", 32'(Herr_stall), (m_err == 2) ? 32'd1 : 32'd0);
        chk("Haddr1", Haddr1, m_a1);
        chk("Haddr2", Haddr2, m_a2);
        chk("Hdata1", Hdata1, m_d1);
        chk("Hdata2", Hdata2, m_d2);
        chk("Hwrite_reg", 32'(Hwrite_reg), 32'(m_w));
    endtask

    // one cycle checked against the model: drive after the edge, check mid-cycle
    task automatic cyc_model(input logic [1:0] tr, input logic rdy, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] pr);
        drive(tr, rdy, wr, addr, wd, pr);
        @(negedge Hclk);
        chk_model();
        @(posedge Hclk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  tr;
        logic        rdy;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] pr;
        logic        e_valid;
        logic [2:0]  e_sel;
        logic [1:0]  e_resp;
        logic        e_stall;
        logic [31:0] e_a1;
        logic [31:0] e_a2;
        logic [31:0] e_d1;
        logic        e_w;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [31:0] a;
        logic [1:0]  tr;
        logic [31:0] addrs[2];

        // tr rdy wr addr wd pr | valid sel resp stall a1 a2 d1 w
        vt[0] = '{2'b10, 1, 1, 32'h8000_0010, 32'h0000_0000, 32'h0,
                  1, 3'b000, 2'b00, 0, 32'h0, 32'h0, 32'h0, 0};
        vt[1] = '{2'b00, 1, 0, 32'h8000_0014, 32'h1111_1111, 32'h0,
                  0, 3'b001, 2'b00, 0, 32'h8000_0010, 32'h0, 32'h0, 1};
        vt[2] = '{2'b10, 1, 0, 32'h83FF_FFFC, 32'h0, 32'hDEAD_BEEF,
                  1, 3'b001, 2'b00, 0, 32'h8000_0014, 32'h8000_0010, 32'h1111_1111, 0};
        vt[3] = '{2'b10, 1, 0, 32'h8400_0000, 32'h0, 32'hDEAD_BEEF,
                  1, 3'b001, 2'b00, 0, 32'h83FF_FFFC, 32'h8000_0014, 32'h0, 0};
        vt[4] = '{2'b11, 1, 0, 32'h8BFF_FFFC, 32'h0, 32'h1234_5678,
                  1, 3'b010, 2'b00, 0, 32'h8400_0000, 32'h83FF_FFFC, 32'h0, 0};
        vt[5] = '{2'b00, 1, 0, 32'h0000_0000, 32'h0, 32'h0,
                  0, 3'b100, 2'b00, 0, 32'h8BFF_FFFC, 32'h8400_0000, 32'h0, 0};
        vt[6] = '{2'b10, 1, 0, 32'h8C00_0000, 32'h0, 32'h0,
                  0, 3'b000, 2'b00, 0, 32'h0, 32'h8BFF_FFFC, 32'h0, 0};
        vt[7] = '{2'b10, 1, 0, 32'h8000_0000, 32'h0, 32'h0,
                  0, 3'b000, 2'b01, 1, 32'h8C00_0000, 32'h0, 32'h0, 0};
        vt[8] = '{2'b00, 1, 0, 32'h0000_0000, 32'h0, 32'h0,
                  0, 3'b001, 2'b01, 0, 32'h8000_0000, 32'h8C00_0000, 32'h0, 0};
        vt[9] = '{2'b00, 1, 0, 32'h0000_0000, 32'h0, 32'h0,
                  0, 3'b000, 2'b00, 0, 32'h0, 32'h8000_0000, 32'h0, 0};

        // reset state
        repeat (2) @(posedge Hclk);
        @(negedge Hclk);
        chk("rst Haddr1", Haddr1, 32'h0);
        chk("rst Haddr2", Haddr2, 32'h0);
        chk("rst Hdata1", Hdata1, 32'h0);
        chk("rst Hdata2", Hdata2, 32'h0);
        chk("rst Hwrite_reg", 32'(Hwrite_reg), 32'h0);
        chk("rst Tempselx", 32'(Tempselx), 32'h0);
        chk("rst Hresp", 32'(Hresp), 32'h0);
        chk("rst Herr_stall", 32'(Herr_stall), 32'h0);
        @(posedge Hclk);
        #1;
        Hreset = 1'b1;

        // directed table
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].tr, vt[i].rdy, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].pr);
            @(negedge Hclk);
            chk($sformatf("vec%0d Valid", i), 32'(Valid), 32'(vt[i].e_valid));
            chk($sformatf("vec%0d Tempselx", i), 32'(Tempselx), 32'(vt[i].e_sel));
            chk($sformatf("vec%0d Hresp", i), 32'(Hresp), 32'(vt[i].e_resp));
            chk($sformatf("vec%0d Herr_stall", i), 32'(Herr_stall), 32'(vt[i].e_stall));
            chk($sformatf("vec%0d Haddr1", i), Haddr1, vt[i].e_a1);
            chk($sformatf("vec%0d Haddr2", i), Haddr2, vt[i].e_a2);
            chk($sformatf("vec%0d Hdata1", i), Hdata1, vt[i].e_d1);
            chk($sformatf("vec%0d Hwrite_reg", i), 32'(Hwrite_reg), 32'(vt[i].e_w));
            chk($sformatf("vec%0d Hrdata", i), Hrdata, vt[i].pr);
            @(posedge Hclk);
            #1;
        end

        // hold: Hreadyin low for three cycles with changing inputs
        cyc_model(2'b10, 1, 1, 32'h8000_0100, 32'hCAFE_0001, 32'h0);
        cyc_model(2'b10, 1, 0, 32'h8400_0200, 32'h1234_5678, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, 0, 1, 32'h8800_0000 + 32'(i * 4), 32'hF0F0_0000 + 32'(i), 32'h0);
            @(negedge Hclk);
            chk("hold Valid", 32'(Valid), 32'h0);
            chk("hold Haddr1", Haddr1, 32'h8400_0200);
            chk("hold Haddr2", Haddr2, 32'h8000_0100);
            chk("hold Hdata1", Hdata1, 32'h1234_5678);
            chk("hold Hdata2", Hdata2, 32'hCAFE_0001);
            chk("hold Hwrite_reg", 32'(Hwrite_reg), 32'h0);
            chk("hold Hresp", 32'(Hresp), 32'h0);
            @(posedge Hclk);
            #1;
        end

        // IDLE and BUSY at mapped and unmapped addresses
        addrs[0] = 32'h8000_0000;
        addrs[1] = 32'h7FFF_FFFF;
        for (int t = 0; t < 2; t++) begin
            for (int j = 0; j < 2; j++) begin
                tr = 2'(t);
                a  = addrs[j];
                drive(tr, 1, 0, a, 32'h0, 32'h0);
                @(negedge Hclk);
                chk("idlebusy Valid", 32'(Valid), 32'h0);
                chk("idlebusy Hresp", 32'(Hresp), 32'h0);
                @(posedge Hclk);
                #1;
            end
        end
        drive(2'b00, 1, 0, 32'h0, 32'h0, 32'h0);
        @(negedge Hclk);
        chk("idlebusy Hresp after", 32'(Hresp), 32'h0);
        chk("idlebusy Herr_stall after", 32'(Herr_stall), 32'h0);
        @(posedge Hclk);
        #1;

        // asynchronous reset during the first error cycle
        cyc_model(2'b10, 1, 0, 32'h9000_0000, 32'h5555_AAAA, 32'h0);
        drive(2'b00, 1, 0, 32'h0, 32'h0, 32'h0);
        #2;
        chk("err1 Hresp", 32'(Hresp), 32'h1);
        chk("err1 Herr_stall", 32'(Herr_stall), 32'h1);
        Hreset = 1'b0;
        #1;
        chk("async Hresp", 32'(Hresp), 32'h0);
        chk("async Herr_stall", 32'(Herr_stall), 32'h0);
        chk("async Haddr1", Haddr1, 32'h0);
        chk("async Haddr2", Haddr2, 32'h0);
        chk("async Hdata1", Hdata1, 32'h0);
        chk("async Hdata2", Hdata2, 32'h0);
        chk("async Hwrite_reg", 32'(Hwrite_reg), 32'h0);
        @(posedge Hclk);
        #1;
        Hreset = 1'b1;
        drive(2'b10, 1, 1, 32'h8000_0000, 32'h0, 32'h0);
        @(negedge Hclk);
        chk("post-reset Valid", 32'(Valid), 32'h1);
        chk("post-reset Hresp", 32'(Hresp), 32'h0);
        @(posedge Hclk);
        #1;

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ra;
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000 + ($urandom % 32'h0C00_0000);
                1: ra = 32'h8000_0000 + ($urandom % 32'h0C00_0000);
                2: ra = $urandom;
                3: ra = 32'h7FFF_FFFC + 32'($urandom_range(0, 8));
                4: ra = 32'h83FF_FFFC + 32'($urandom_range(0, 8));
                default: ra = 32'h8BFF_FFFC + 32'($urandom_range(0, 8));
            endcase
            cyc_model(2'($urandom), ($urandom_range(0, 4) != 0), 1'($urandom),
                      ra, $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_slave_if.md
Name: ahb_slave_if

Overview:
- AHB-side front end of the AHB-to-APB bridge; sits directly upstream of the bridge control FSM.
- Qualifies AHB transfers and produces Valid for the FSM.
- Pipelines address, write data and direction into the two-deep registers the FSM consumes (Haddr1/2, Hdata1/2, Hwrite_reg).
- Decodes the APB slave select, passes APB read data back to AHB, and generates the two-cycle AHB ERROR response for unmapped addresses.

Parameters:
- SLV0_BASE, 32'h8000_0000, base of APB slave 0 region
- SLV1_BASE, 32'h8400_0000, base of APB slave 1 region
- SLV2_BASE, 32'h8800_0000, base of APB slave 2 region
- REGION_SIZE, 32'h0400_0000, byte size of each slave region

Ports:
- Hclk  input  1  bridge clock; all registers rise-edge
- Hreset  input  1  asynchronous, active-low reset
- Hwrite  input  1  AHB direction, 1 = write
- Hreadyin  input  1  AHB bus ready
- Htrans  input  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- Haddr  input  32  AHB address-phase address
- Hwdata  input  32  AHB write data (data phase)
- Prdata  input  32  APB read data from selected slave
- Valid  output  1  qualified, mapped transfer this cycle
- Haddr1  output  32  address, 1 stage delayed
- Haddr2  output  32  address, 2 stages delayed
- Hdata1  output  32  write data, 1 stage delayed
- Hdata2  output  32  write data, 2 stages delayed
- Hwrite_reg  output  1  Hwrite, 1 stage delayed
- Tempselx  output  3  one-hot APB select decoded from Haddr1
- Hrdata  output  32  AHB read data
- Hresp  output  2  AHB response: 00 OKAY, 01 ERROR
- Herr_stall  output  1  forces AHB Hready low during first ERROR cycle (top level ANDs its inverse into Hready)

Behaviour:
- Reset (Hreset=0, asynchronous): Haddr1, Haddr2, Hdata1, Hdata2 = 0; Hwrite_reg = 0; error FSM = OKAY. Hence Tempselx = 000, Hresp = 00, Herr_stall = 0.
- Mapped: Haddr in [SLV0_BASE, SLV2_BASE+REGION_SIZE-1]. Defaults give 0x8000_0000..0x8BFF_FFFF.
- Active: Hreadyin=1 and Htrans[1]=1 (NONSEQ or SEQ).
- Valid is combinational, same cycle as the address phase: Active & Mapped & (state==OKAY).
- Pipeline registers are enabled only when Hreadyin=1. On each such edge:
  - Haddr1<=Haddr, Haddr2<=Haddr1
  - Hdata1<=Hwdata, Hdata2<=Hdata1
  - Hwrite_reg<=Hwrite
- Hreadyin=0: all pipeline registers hold their values.
- Tempselx is combinational from Haddr1:
  - SLV0 region -> 001
  - SLV1 region -> 010
  - SLV2 region -> 100
  - otherwise -> 000
  - Region bounds are inclusive base, exclusive base+REGION_SIZE. Outputs are never multi-hot.
- Hrdata = Prdata, combinational, no latency.
- Error FSM states: OKAY, ERR1, ERR2.
  - OKAY -> ERR1 when Active & !Mapped. Otherwise stay in OKAY.
  - ERR1 -> ERR2 unconditionally.
  - ERR2 -> OKAY unconditionally.
- Error FSM outputs:
  - OKAY: Hresp=00, Herr_stall=0
  - ERR1: Hresp=01, Herr_stall=1
  - ERR2: Hresp=01, Herr_stall=0
- During ERR1 and ERR2, Valid is forced to 0 and no new error is detected, even for Active transfers.
- IDLE or BUSY Htrans: Valid=0, no error. The pipeline still advances if Hreadyin=1.
- Unmapped address never reaches the FSM (Valid=0). Its Haddr1 still registers and decodes to Tempselx=000.
- Reset asserted mid-error: FSM returns to OKAY immediately; Hresp=00 and Herr_stall=0 without waiting for a clock.
- Back-to-back NONSEQ/SEQ mapped transfers: Valid stays 1 every cycle. Haddr2/Hdata2 expose the older transfer, as the bridge needs for pipelined writes.

Test Plan:
- Reset, then write NONSEQ Haddr=0x8000_0010, Hwrite=1, Hreadyin=1 -> Valid=1 that cycle. Next edge: Haddr1=0x8000_0010, Hwrite_reg=1, Tempselx=001. Following edge: Haddr2=0x8000_0010, Hdata1=data-phase Hwdata.
- Reads at 0x83FF_FFFC, 0x8400_0000, 0x8BFF_FFFC -> Tempselx 001, 010, 100 one cycle later. With Prdata=0xDEAD_BEEF, Hrdata=0xDEAD_BEEF the same cycle.
- NONSEQ to 0x8C00_0000 -> Valid=0. Next cycle Hresp=01 and Herr_stall=1; then Hresp=01 and Herr_stall=0; then Hresp=00. A mapped NONSEQ presented during ERR1 gives Valid=0.
- Hreadyin=0 for 3 cycles with changing Haddr/Hwdata -> Haddr1/2, Hdata1/2 and Hwrite_reg unchanged; Valid=0.
- Htrans=01 (BUSY) and 00 (IDLE) at 0x8000_0000 and at 0x7FFF_FFFF -> Valid=0, Hresp stays 00.
- Trigger error, deassert Hreset during ERR1 -> Hresp=00 and Herr_stall=0 asynchronously, and all pipeline registers = 0. After release, a mapped NONSEQ gives Valid=1.
